// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter sharing one regfile write port between the ALU (A) and the
// load unit (B): one-entry holds per side, oldest-first issue, round-robin on ties, and operand forwarding.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_wd,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_wd,
  output logic              we,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] q_rs1,
  input  logic [ADDR_W-1:0] q_rs2,
  output logic              fwd1_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd2_data,
  output logic              busy
);

  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  logic              ha_v_q, ha_v_d, hb_v_q, hb_v_d;
  logic [ADDR_W-1:0] ha_rd_q, ha_rd_d, hb_rd_q, hb_rd_d;
  logic [DATA_W-1:0] ha_wd_q, ha_wd_d, hb_wd_q, hb_wd_d;
  logic              same_q, same_d, a_older_q, a_older_d, rr_q, rr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              grant_a_s, grant_b_s, load_a_s, load_b_s, a_young_s;
  logic [DATA_W:0]   fwd1_s, fwd2_s;

  // Youngest hold first, then the older hold, then the write in flight at the output stage.
  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [ADDR_W-1:0] q, input logic a_young,
    input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] awd,
    input logic bv, input logic [ADDR_W-1:0] brd, input logic [DATA_W-1:0] bwd,
    input logic ov, input logic [ADDR_W-1:0] ord, input logic [DATA_W-1:0] owd);
    logic hit_a, hit_b, hit_o;
    logic [DATA_W:0] r;
    hit_a = av && (ard == q);
    hit_b = bv && (brd == q);
    hit_o = ov && (ord == q);
    if (q == {ADDR_W{1'b0}})      r = {(DATA_W+1){1'b0}};
    else if (a_young && hit_a)    r = {1'b1, awd};
    else if (!a_young && hit_b)   r = {1'b1, bwd};
    else if (hit_a)               r = {1'b1, awd};
    else if (hit_b)               r = {1'b1, bwd};
    else if (hit_o)               r = {1'b1, owd};
    else                          r = {(DATA_W+1){1'b0}};
    return r;
  endfunction

  // Grant selection: single valid hold wins, otherwise age, otherwise round-robin.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (ha_v_q && hb_v_q) begin
      if (same_q) begin
        if (rr_q == SIDE_A) grant_a_s = 1'b1;
        else                grant_b_s = 1'b1;
      end else if (a_older_q) begin
        grant_a_s = 1'b1;
      end else begin
        grant_b_s = 1'b1;
      end
    end else if (ha_v_q) begin
      grant_a_s = 1'b1;
    end else if (hb_v_q) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
    end
  end

  assign a_ready  = ~rst & (~ha_v_q | grant_a_s);
  assign b_ready  = ~rst & (~hb_v_q | grant_b_s);
  assign load_a_s = a_valid & a_ready & (a_rd != {ADDR_W{1'b0}});
  assign load_b_s = b_valid & b_ready & (b_rd != {ADDR_W{1'b0}});

  // Next state for holds, age tracking, round-robin pointer and output stage.
  always_comb begin
    ha_v_d  = load_a_s | (ha_v_q & ~grant_a_s);
    hb_v_d  = load_b_s | (hb_v_q & ~grant_b_s);
    ha_rd_d = load_a_s ? a_rd : ha_rd_q;
    ha_wd_d = load_a_s ? a_wd : ha_wd_q;
    hb_rd_d = load_b_s ? b_rd : hb_rd_q;
    hb_wd_d = load_b_s ? b_wd : hb_wd_q;
    same_d    = same_q;
    a_older_d = a_older_q;
    if (ha_v_d && hb_v_d) begin
      if (load_a_s && load_b_s) begin
        same_d = 1'b1;
      end else if (load_a_s) begin
        same_d    = 1'b0;
        a_older_d = 1'b0;
      end else if (load_b_s) begin
        same_d    = 1'b0;
        a_older_d = 1'b1;
      end else begin
        same_d = same_q;
      end
    end else begin
      same_d = 1'b0;
    end
    rr_d = (ha_v_q && hb_v_q && same_q) ? ~rr_q : rr_q;
    we_d = grant_a_s | grant_b_s;
    if (grant_a_s) begin
      rd_d = ha_rd_q;
      wd_d = ha_wd_q;
    end else if (grant_b_s) begin
      rd_d = hb_rd_q;
      wd_d = hb_wd_q;
    end else begin
      rd_d = {ADDR_W{1'b0}};
      wd_d = {DATA_W{1'b0}};
    end
  end

  // State registers; reset discards pending holds and the in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ha_v_q <= 1'b0;  ha_rd_q <= {ADDR_W{1'b0}};  ha_wd_q <= {DATA_W{1'b0}};
      hb_v_q <= 1'b0;  hb_rd_q <= {ADDR_W{1'b0}};  hb_wd_q <= {DATA_W{1'b0}};
      same_q <= 1'b0;  a_older_q <= 1'b0;  rr_q <= SIDE_A;
      we_q   <= 1'b0;  rd_q <= {ADDR_W{1'b0}};  wd_q <= {DATA_W{1'b0}};
    end else begin
      ha_v_q <= ha_v_d;  ha_rd_q <= ha_rd_d;  ha_wd_q <= ha_wd_d;
      hb_v_q <= hb_v_d;  hb_rd_q <= hb_rd_d;  hb_wd_q <= hb_wd_d;
      same_q <= same_d;  a_older_q <= a_older_d;  rr_q <= rr_d;
      we_q   <= we_d;  rd_q <= rd_d;  wd_q <= wd_d;
    end
  end

  // With same-age holds the side rr_ptr does not point to is the younger one.
  always_comb begin
    if (ha_v_q && hb_v_q) begin
      if (same_q) a_young_s = (rr_q == SIDE_B);
      else        a_young_s = ~a_older_q;
    end else begin
      a_young_s = ha_v_q;
    end
  end

  assign fwd1_s = fwd_lookup(q_rs1, a_young_s, ha_v_q, ha_rd_q, ha_wd_q,
                             hb_v_q, hb_rd_q, hb_wd_q, we_q, rd_q, wd_q);
  assign fwd2_s = fwd_lookup(q_rs2, a_young_s, ha_v_q, ha_rd_q, ha_wd_q,
                             hb_v_q, hb_rd_q, hb_wd_q, we_q, rd_q, wd_q);

  assign fwd1_hit  = fwd1_s[DATA_W];
  assign fwd1_data = fwd1_s[DATA_W-1:0];
  assign fwd2_hit  = fwd2_s[DATA_W];
  assign fwd2_data = fwd2_s[DATA_W-1:0];
  assign we        = we_q;
  assign rd        = rd_q;
  assign wd        = wd_q;
  assign busy      = ha_v_q | hb_v_q | we_q;

endmodule
